// File: rtl/seq_stage_controller.sv
// rtl/seq_stage_controller.sv - Y86-64 SEQ stage sequencer
// One stage enable per cycle, data-memory req/ack handshake, status and counters.
module seq_stage_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             mem_req,
  output logic             writeback_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [2:0]       STAT_AOK  = 3'd1;
  localparam logic [2:0]       STAT_HLT  = 3'd2;
  localparam logic [2:0]       STAT_ADR  = 3'd3;
  localparam logic [2:0]       STAT_INS  = 3'd4;
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state, w_next_state;
  logic [2:0]       r_stat, w_next_stat;
  logic [3:0]       r_icode;
  logic [7:0]       r_wait, w_next_wait;
  logic [CNT_W-1:0] r_cycle_count, r_instr_count;
  logic             w_clr_cnt, w_retire, w_is_mem, w_busy;

  // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
  assign w_is_mem = (r_icode == 4'h4) || (r_icode == 4'h5) || (r_icode == 4'h8) ||
                    (r_icode == 4'h9) || (r_icode == 4'hA) || (r_icode == 4'hB);
  assign w_busy   = (r_state != S_IDLE) && (r_state != S_HALTED);

  always_comb begin
    w_next_state = r_state;
    w_next_stat  = r_stat;
    w_next_wait  = r_wait;
    w_clr_cnt    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_next_stat  = STAT_AOK;
          w_clr_cnt    = 1'b1;
        end
      end
      S_FETCH: begin
        if (imem_error) begin
          w_next_stat  = STAT_ADR;
          w_next_state = S_HALTED;
        end else if (!instr_valid) begin
          w_next_stat  = STAT_INS;
          w_next_state = S_HALTED;
        end else if (icode == 4'h0) begin
          w_next_stat  = STAT_HLT;
          w_next_state = S_HALTED;
        end else begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE:  w_next_state = S_EXECUTE;
      S_EXECUTE: begin
        w_next_state = S_MEMORY;
        w_next_wait  = 8'd0;
      end
      S_MEMORY: begin
        // an ack on the final allowed cycle still completes the access
        if (!w_is_mem) begin
          w_next_state = S_WRITEBACK;
        end else if (mem_ack) begin
          w_next_wait = 8'd0;
          if (dmem_error) begin
            w_next_stat  = STAT_ADR;
            w_next_state = S_HALTED;
          end else begin
            w_next_state = S_WRITEBACK;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_next_wait  = 8'd0;
          w_next_stat  = STAT_ADR;
          w_next_state = S_HALTED;
        end else begin
          w_next_wait = r_wait + 8'd1;
        end
      end
      S_WRITEBACK: w_next_state = S_PCUPD;
      S_PCUPD: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_stat        <= STAT_AOK;
      r_icode       <= 4'h0;
      r_wait        <= 8'd0;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_stat  <= w_next_stat;
      r_wait  <= w_next_wait;
      if (r_state == S_FETCH) r_icode <= icode;
      if (w_clr_cnt) begin
        r_cycle_count <= '0;
        r_instr_count <= '0;
      end else begin
        if (w_busy && (r_cycle_count != CNT_MAX)) r_cycle_count <= r_cycle_count + CNT_W'(1);
        if (w_retire && (r_instr_count != CNT_MAX)) r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign fetch_en     = (r_state == S_FETCH);
  assign decode_en    = (r_state == S_DECODE);
  assign execute_en   = (r_state == S_EXECUTE);
  assign memory_en    = (r_state == S_MEMORY);
  assign mem_req      = memory_en && w_is_mem;
  assign writeback_en = (r_state == S_WRITEBACK);
  assign pc_en        = (r_state == S_PCUPD);
  assign stat         = r_stat;
  assign busy         = w_busy;
  assign cycle_count  = r_cycle_count;
  assign instr_count  = r_instr_count;

endmodule

// File: tb/tb_seq_stage_controller.sv
// tb/tb_seq_stage_controller.sv - scoreboard bench for seq_stage_controller
// Programs are expanded into expected per-cycle stage vectors; a monitor pops and compares.
module tb_seq_stage_controller;

  localparam int TO = 15;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic        instr_valid = 1'b1, imem_error = 1'b0, mem_ack = 1'b0, dmem_error = 1'b0;
  logic        fetch_en, decode_en, execute_en, memory_en, mem_req, writeback_en, pc_en, busy;
  logic [2:0]  stat;
  logic [31:0] cycle_count, instr_count;

  seq_stage_controller #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .mem_req(mem_req), .writeback_en(writeback_en), .pc_en(pc_en),
    .stat(stat), .busy(busy), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ic;
    bit         valid;
    bit         imerr;
    int         delay;
    bit         derr;
  } instr_t;

  typedef struct {
    logic [2:0] st;
    int         cycles;
    int         instrs;
  } halt_t;

  // {fetch, decode, execute, memory, mem_req, writeback, pc}
  localparam logic [6:0] V_F = 7'b1000000, V_D = 7'b0100000, V_E = 7'b0010000,
                         V_M = 7'b0001000, V_MR = 7'b0001100, V_W = 7'b0000010, V_P = 7'b0000001;

  logic [6:0] exp_q[$];
  halt_t      halt_q[$];
  instr_t     prog[$];
  int         checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
           (ic == 4'hA) || (ic == 4'hB);
  endfunction

  function automatic bit ends_at_fetch(input instr_t x);
    return x.imerr || !x.valid || (x.ic == 4'h0);
  endfunction

  task automatic push_model();
    int cyc = 0, ret = 0;
    logic [2:0] st = 3'd1;
    foreach (prog[i]) begin
      exp_q.push_back(V_F); cyc++;
      if (prog[i].imerr) begin st = 3'd3; break; end
      if (!prog[i].valid) begin st = 3'd4; break; end
      if (prog[i].ic == 4'h0) begin st = 3'd2; break; end
      exp_q.push_back(V_D); exp_q.push_back(V_E); cyc += 2;
      if (is_mem(prog[i].ic)) begin
        if (prog[i].delay + 1 > TO) begin
          repeat (TO) exp_q.push_back(V_MR);
          cyc += TO; st = 3'd3; break;
        end
        repeat (prog[i].delay + 1) exp_q.push_back(V_MR);
        cyc += prog[i].delay + 1;
        if (prog[i].derr) begin st = 3'd3; break; end
      end else begin
        exp_q.push_back(V_M); cyc++;
      end
      exp_q.push_back(V_W); exp_q.push_back(V_P); cyc += 2; ret++;
    end
    halt_q.push_back('{st, cyc, ret});
  endtask

  task automatic add(input logic [3:0] ic, input bit valid, input bit imerr,
                     input int delay, input bit derr);
    instr_t x;
    x.ic = ic; x.valid = valid; x.imerr = imerr; x.delay = delay; x.derr = derr;
    prog.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_vec", {fetch_en, decode_en, execute_en, memory_en, mem_req, writeback_en, pc_en}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stat", stat, 1);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_instrs", instr_count, 0);
    exp_q.delete(); halt_q.delete();
    start = 0; mem_ack = 0; dmem_error = 0; imem_error = 0; instr_valid = 1;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    #1 push_model();
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_fetch(output bit ok);
    int n = 0;
    while (!fetch_en && n < 200) begin @(negedge clk); n++; end
    ok = fetch_en;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL fetch_wait: fetch_en not seen within 200 cycles, expected 1");
    end
  endtask

  task automatic drive_prog();
    bit ok, first = 1;
    pulse_start();
    foreach (prog[i]) begin
      wait_fetch(ok);
      if (!ok) begin do_reset(); return; end
      if (first) begin
        chk("start_stat", stat, 1);
        chk("start_cycles", cycle_count, 0);
        chk("start_instrs", instr_count, 0);
        first = 0;
      end
      icode = prog[i].ic; instr_valid = prog[i].valid; imem_error = prog[i].imerr;
      @(negedge clk);
      icode = 4'($urandom); instr_valid = 1'($urandom); imem_error = 1'b0;
      if (ends_at_fetch(prog[i])) break;
      if ($urandom_range(0, 3) == 0) start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      if (is_mem(prog[i].ic)) begin
        for (int j = 0; ; j++) begin
          mem_ack    = (j == prog[i].delay);
          dmem_error = (j == prog[i].delay) ? prog[i].derr : 1'($urandom);
          @(negedge clk);
          if (j == prog[i].delay || j == TO - 1) break;
        end
        mem_ack = 1'b0; dmem_error = 1'b0;
        if (prog[i].delay >= TO) begin
          mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
        end
      end
    end
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: one expected vector per busy cycle, one halt record per busy->idle edge.
  initial begin
    bit prev = 0;
    logic [6:0] v;
    halt_t h;
    forever begin
      @(negedge clk);
      v = {fetch_en, decode_en, execute_en, memory_en, mem_req, writeback_en, pc_en};
      if (!rst_n) begin
        prev = 0;
      end else begin
        if (busy) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_busy: got busy=1 vec=%b expected idle", v);
          end else begin
            chk("stage_vec", v, exp_q.pop_front());
          end
        end else begin
          chk("idle_vec", v, 0);
          if (prev) begin
            if (halt_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_halt: got halt with no expected record, expected none");
            end else begin
              h = halt_q.pop_front();
              chk("halt_stat", stat, h.st);
              chk("halt_cycles", cycle_count, h.cycles);
              chk("halt_instrs", instr_count, h.instrs);
            end
          end
        end
        prev = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    repeat (2) @(negedge clk);
    chk("reset_vec", {fetch_en, decode_en, execute_en, memory_en, mem_req, writeback_en, pc_en}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stat", stat, 1);
    chk("reset_counts", {cycle_count, instr_count}, 0);
    #2 rst_n = 1'b1;

    prog.delete(); add(1, 1, 0, 0, 0); add(1, 1, 0, 0, 0); add(1, 1, 0, 0, 0); add(0, 1, 0, 0, 0);
    drive_prog();
    chk("nop_cycle_count", cycle_count, 19);
    chk("nop_instr_count", instr_count, 3);
    chk("nop_stat", stat, 2);

    prog.delete(); add(5, 1, 0, 3, 0); add(0, 1, 0, 0, 0);
    drive_prog();
    prog.delete(); add(4, 1, 0, 0, 1);
    drive_prog();
    prog.delete(); add(4'hA, 1, 0, TO + 5, 0);
    drive_prog();
    chk("timeout_mem_req", mem_req, 0);
    prog.delete(); add(4'hC, 0, 0, 0, 0);
    drive_prog();
    prog.delete(); add(2, 0, 1, 0, 0);
    drive_prog();

    // async reset while a memory request is outstanding
    prog.delete(); add(5, 1, 0, TO + 5, 0);
    pulse_start();
    wait_fetch(ok);
    icode = 4'h5; instr_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_mem_req", mem_req, 1);
    do_reset();

    for (int p = 0; p < 25; p++) begin
      prog.delete();
      for (int i = 0; i < 8; i++) begin
        instr_t x;
        bit last;
        x.valid = 1; x.imerr = 0; x.derr = 0; x.delay = 0;
        x.ic = 4'($urandom_range(1, 11));
        if (is_mem(x.ic)) x.delay = $urandom_range(0, 4);
        last = (i == 7) || ($urandom_range(0, 4) == 0);
        if (last) begin
          case ($urandom_range(0, 4))
            0: x.ic = 4'h0;
            1: begin x.valid = 0; x.ic = 4'($urandom); end
            2: begin x.imerr = 1; x.valid = 1'($urandom); end
            3: begin x.ic = 4'h8; x.derr = 1; x.delay = $urandom_range(0, 3); end
            default: begin x.ic = 4'hB; x.delay = TO + 2; end
          endcase
        end
        prog.push_back(x);
        if (last) break;
      end
      drive_prog();
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("halt_q_drained", halt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
